mm_tile_sched: RTL
==================

MM_TILE_SCHED -- requirements
Module: mm_tile_sched

Interface
REQ-001 Parameter ROW_A, default 8: rows of input matrix A.
REQ-002 Parameter K_DIM, default 8: columns of A and rows of weight W.
REQ-003 Parameter COL_W, default 8: columns of W.
REQ-004 Parameter BLOCK_SIZE, default 2: rows per block; divides ROW_A and K_DIM.
REQ-005 Parameter CHUNK_SIZE, default 4: columns per block; divides K_DIM and COL_W.
REQ-006 Parameter DRAIN_LAT, default 3: MAC pipeline cycles after the last issued tile.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 start  input  1  one-cycle pulse; honoured only in IDLE or DONE.
REQ-010 row_valid  input  1  upstream row of A and row of W presented this cycle.
REQ-011 row_ready  output  1  scheduler accepts the row; transfer when row_valid && row_ready.
REQ-012 buf_a_en, buf_w_en  output  1 each  write enables to the A and W reorder buffers.
REQ-013 slice_ready  input  1  both buffers present a valid block this cycle.
REQ-014 mac_en  output  1  issue current block pair to the MAC cores.
REQ-015 mac_first, mac_last  output  1 each  first / last k-step of the current output tile.
REQ-016 tile_row, tile_col, k_idx  output  $clog2 of the respective tile count (min 1)  current indices.
REQ-017 busy  output  1  high outside IDLE and DONE.
REQ-018 done  output  1  one-cycle pulse on entry to DONE.

Function
REQ-019 States SHALL be IDLE, LOAD, ISSUE, DRAIN, DONE.
REQ-020 IDLE/DONE -> LOAD on start; row counter, all indices cleared same edge.
REQ-021 In LOAD, row_ready SHALL be 1; each accepted row SHALL pulse buf_a_en (while rows < ROW_A) and buf_w_en (while rows < K_DIM) in the same cycle as the transfer.
REQ-022 LOAD -> ISSUE on the edge accepting row max(ROW_A,K_DIM)-1; row_ready SHALL be 0 from the next cycle.
REQ-023 In ISSUE, mac_en SHALL equal slice_ready; indices advance only on cycles with mac_en.
REQ-024 Loop order k_idx innermost (K_DIM/CHUNK_SIZE), then tile_col (COL_W/CHUNK_SIZE), then tile_row (ROW_A/BLOCK_SIZE); each wraps to 0 and carries.
REQ-025 mac_first = mac_en && k_idx==0; mac_last = mac_en && k_idx==last.
REQ-026 ISSUE -> DRAIN after the mac_en cycle with all three indices at their maxima.
REQ-027 DRAIN SHALL last exactly DRAIN_LAT cycles, then DONE; done asserted the first DONE cycle only.
REQ-028 start during LOAD, ISSUE or DRAIN SHALL be ignored.
REQ-029 row_valid outside LOAD SHALL be ignored; slice_ready outside ISSUE SHALL be ignored.

Reset
REQ-030 On rst_n low, immediately: state IDLE; row_ready, buf_a_en, buf_w_en, mac_en, mac_first, mac_last, busy, done = 0; indices and counters = 0.
REQ-031 Reset mid-operation SHALL abort with no further enables; a subsequent start restarts from LOAD.

Configuration
REQ-032 With SCHED_PERF_CNT_EN defined, output perf_cycles (32 bits) SHALL count cycles from start to done, saturating, cleared on start; without it the port and counter SHALL not exist.

Structure
REQ-033 Shared package SHALL hold the state enum and tile-count/index-width localparam functions.
REQ-034 One sub-module, tile_idx_counter (three-level nested wrap counter with carry/last flags), is natural; everything else inline.

Verification
REQ-035 Defaults, start, row_valid held 1: 8 load cycles, 2*2*4=16 mac_en cycles with slice_ready=1, done 3 cycles after last mac_en.
REQ-036 row_valid toggling 1/0: exactly 8 buf_a_en and 8 buf_w_en pulses, none while row_valid=0.
REQ-037 slice_ready low for 5 cycles mid-ISSUE: indices freeze, no mac_en, sequence resumes unchanged.
REQ-038 mac_first/mac_last observed on k_idx 0 and 1 of every tile; 8 pairs total with defaults.
REQ-039 rst_n low during ISSUE at tile (1,0): all outputs 0 asynchronously; new start completes full 16-issue run.
REQ-040 start pulsed during DRAIN: ignored, single done pulse; with SCHED_PERF_CNT_EN, perf_cycles matches measured cycle count.

Source files
------------

// File: rtl/mm_tile_sched_pkg.sv
// Shared types and sizing helpers for the matrix-multiply tile scheduler.
package mm_tile_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_e;

    function automatic int unsigned tile_cnt(input int unsigned dim, input int unsigned blk);
        return dim / blk;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mm_tile_sched_if.sv
// Row-load / MAC-issue handshake bundle between the scheduler (master) and its environment (slave).
interface mm_tile_sched_if #(
    parameter int unsigned ROW_A      = 8,
    parameter int unsigned K_DIM      = 8,
    parameter int unsigned COL_W      = 8,
    parameter int unsigned BLOCK_SIZE = 2,
    parameter int unsigned CHUNK_SIZE = 4
);
    import mm_tile_sched_pkg::*;

    localparam int unsigned RW = idx_w(tile_cnt(ROW_A, BLOCK_SIZE));
    localparam int unsigned CW = idx_w(tile_cnt(COL_W, CHUNK_SIZE));
    localparam int unsigned KW = idx_w(tile_cnt(K_DIM, CHUNK_SIZE));

    logic          start;
    logic          row_valid;
    logic          row_ready;
    logic          buf_a_en;
    logic          buf_w_en;
    logic          slice_ready;
    logic          mac_en;
    logic          mac_first;
    logic          mac_last;
    logic [RW-1:0] tile_row;
    logic [CW-1:0] tile_col;
    logic [KW-1:0] k_idx;
    logic          busy;
    logic          done;

    modport master (
        input  start, row_valid, slice_ready,
        output row_ready, buf_a_en, buf_w_en, mac_en, mac_first, mac_last,
               tile_row, tile_col, k_idx, busy, done
    );

    modport slave (
        output start, row_valid, slice_ready,
        input  row_ready, buf_a_en, buf_w_en, mac_en, mac_first, mac_last,
               tile_row, tile_col, k_idx, busy, done
    );

endinterface

// File: rtl/mm_tile_sched_tile_idx_counter.sv
// Three-level nested wrap counter: k innermost, then column, then row, with last flags.
module tile_idx_counter
    import mm_tile_sched_pkg::*;
#(
    parameter int unsigned N_ROW = 4,
    parameter int unsigned N_COL = 2,
    parameter int unsigned N_K   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clr,
    input  logic                    i_adv,
    output logic [idx_w(N_ROW)-1:0] o_row,
    output logic [idx_w(N_COL)-1:0] o_col,
    output logic [idx_w(N_K)-1:0]   o_k,
    output logic                    o_k_first,
    output logic                    o_k_last,
    output logic                    o_all_last
);
    localparam int unsigned RW = idx_w(N_ROW);
    localparam int unsigned CW = idx_w(N_COL);
    localparam int unsigned KW = idx_w(N_K);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [KW-1:0] r_k;
    logic          w_row_last;
    logic          w_col_last;
    logic          w_k_last;

    assign w_row_last = (r_row == RW'(N_ROW - 1));
    assign w_col_last = (r_col == CW'(N_COL - 1));
    assign w_k_last   = (r_k == KW'(N_K - 1));

    assign o_row      = r_row;
    assign o_col      = r_col;
    assign o_k        = r_k;
    assign o_k_first  = (r_k == '0);
    assign o_k_last   = w_k_last;
    assign o_all_last = w_row_last && w_col_last && w_k_last;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else if (i_clr) begin
            r_row <= '0;
            r_col <= '0;
            r_k   <= '0;
        end else if (i_adv) begin
            if (w_k_last) begin
                r_k <= '0;
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end else begin
                r_k <= r_k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_tile_sched.sv
// Tile scheduler: loads A/W rows into reorder buffers, issues block pairs to MAC cores, drains.
// Optional SCHED_PERF_CNT_EN adds o_perf_cycles, a saturating start-to-done cycle counter.
module mm_tile_sched
    import mm_tile_sched_pkg::*;
#(
    parameter int unsigned ROW_A      = 8,
    parameter int unsigned K_DIM      = 8,
    parameter int unsigned COL_W      = 8,
    parameter int unsigned BLOCK_SIZE = 2,
    parameter int unsigned CHUNK_SIZE = 4,
    parameter int unsigned DRAIN_LAT  = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    mm_tile_sched_if.master bus
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_cycles
`endif
);
    localparam int unsigned N_ROW = tile_cnt(ROW_A, BLOCK_SIZE);
    localparam int unsigned N_COL = tile_cnt(COL_W, CHUNK_SIZE);
    localparam int unsigned N_K   = tile_cnt(K_DIM, CHUNK_SIZE);
    localparam int unsigned NROWS = max_u(ROW_A, K_DIM);
    localparam int unsigned RCW   = $clog2(NROWS + 1);
    localparam int unsigned DCW   = idx_w(DRAIN_LAT);

    sched_state_e r_state;
    sched_state_e w_state_nxt;
    logic [RCW-1:0] r_rows;
    logic [DCW-1:0] r_drain;
    logic           r_done;

    logic w_start;
    logic w_accept;
    logic w_row_ready;
    logic w_buf_a_en;
    logic w_buf_w_en;
    logic w_mac_en;
    logic w_busy;
    logic w_k_first;
    logic w_k_last;
    logic w_all_last;

    logic [idx_w(N_ROW)-1:0] w_row;
    logic [idx_w(N_COL)-1:0] w_col;
    logic [idx_w(N_K)-1:0]   w_k;

    tile_idx_counter #(
        .N_ROW (N_ROW),
        .N_COL (N_COL),
        .N_K   (N_K)
    ) u_idx (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clr      (w_start),
        .i_adv      (w_mac_en),
        .o_row      (w_row),
        .o_col      (w_col),
        .o_k        (w_k),
        .o_k_first  (w_k_first),
        .o_k_last   (w_k_last),
        .o_all_last (w_all_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_row_ready = 1'b0;
        w_accept    = 1'b0;
        w_buf_a_en  = 1'b0;
        w_buf_w_en  = 1'b0;
        w_mac_en    = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_start = bus.start;
                if (bus.start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_busy      = 1'b1;
                w_row_ready = 1'b1;
                w_accept    = bus.row_valid;
                w_buf_a_en  = bus.row_valid && (r_rows < RCW'(ROW_A));
                w_buf_w_en  = bus.row_valid && (r_rows < RCW'(K_DIM));
                if (bus.row_valid && (r_rows == RCW'(NROWS - 1))) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                w_busy   = 1'b1;
                w_mac_en = bus.slice_ready;
                if (bus.slice_ready && w_all_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (r_drain == DCW'(DRAIN_LAT - 1)) w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rows  <= '0;
            r_drain <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= (r_state == S_DRAIN) && (w_state_nxt == S_DONE);
            if (w_start)       r_rows <= '0;
            else if (w_accept) r_rows <= r_rows + 1'b1;
            r_drain <= (r_state == S_DRAIN) ? r_drain + 1'b1 : '0;
        end
    end

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] r_perf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                   r_perf <= '0;
        else if (w_start)               r_perf <= '0;
        else if (w_busy && r_perf != '1) r_perf <= r_perf + 1'b1;
    end

    assign o_perf_cycles = r_perf;
`endif

    assign bus.row_ready = w_row_ready;
    assign bus.buf_a_en  = w_buf_a_en;
    assign bus.buf_w_en  = w_buf_w_en;
    assign bus.mac_en    = w_mac_en;
    assign bus.mac_first = w_mac_en && w_k_first;
    assign bus.mac_last  = w_mac_en && w_k_last;
    assign bus.tile_row  = w_row;
    assign bus.tile_col  = w_col;
    assign bus.k_idx     = w_k;
    assign bus.busy      = w_busy;
    assign bus.done      = r_done;

endmodule
